// File: rtl/vpu_scanout_rx_if.sv
// Pixel stream leaving the scanout receiver: one beat per pixel with its
// screen coordinates and frame/line markers, under valid/ready flow control.
interface vpu_scanout_rx_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [8:0]  out_x;
  logic [7:0]  out_y;
  logic        out_sof;
  logic        out_eol;

  // Producer side (the receiver).
  modport master (
    output out_valid, out_data, out_x, out_y, out_sof, out_eol,
    input  out_ready
  );

  // Consumer side (downstream sink).
  modport slave (
    input  out_valid, out_data, out_x, out_y, out_sof, out_eol,
    output out_ready
  );
endinterface

// File: rtl/vpu_scanout_rx.sv
// VPU scanout receiver: captures visible pixels into two ping-pong line
// buffers and replays each complete line as a valid/ready pixel stream
// tagged with its column/row, start-of-frame and end-of-line markers.
module vpu_scanout_rx #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dot_clk,
  input  logic [31:0]            color,
  input  logic                   hsync,
  input  logic                   vsync,
  vpu_scanout_rx_if.master       beat,
  output logic                   overflow,
  output logic                   short_line
);

  localparam logic [8:0] X_FULL = 9'(SCREEN_W);
  localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DRAIN} rd_state_t;

  // Sync edge detection.
  logic hsync_q, vsync_q;
  logic hs_rise, hs_fall, vs_fall;

  // Write (capture) side.
  logic       line_active;
  logic       line_go;
  logic       start_ok;
  logic       capture;
  logic       commit;
  logic [8:0] wr_x;
  logic [7:0] wr_y;
  logic       wr_sel;

  // Buffer bookkeeping shared by both sides.
  logic [1:0] full;
  logic [7:0] row_tag [2];

  // Read (replay) side.
  rd_state_t   state, state_next;
  logic        rd_sel;
  logic [8:0]  rd_x;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;
  logic        accept;
  logic        drain;

  logic [31:0] mem [2][SCREEN_W];

  // Edge strobes and capture qualifiers derived from the registered syncs.
  always_comb begin
    hs_rise  = hsync && !hsync_q;
    hs_fall  = hsync_q && !hsync;
    vs_fall  = vsync_q && !vsync;
    start_ok = hs_rise && vsync;
    line_go  = line_active || (start_ok && !full[wr_sel]);
    capture  = dot_clk && hsync && vsync && line_go && (wr_x != X_FULL);
    commit   = hs_fall && line_active && (wr_x == X_FULL);
  end

  // Write-side state: line tracking, column/row counters, sticky flags.
  // hsync_q resets high so a line already in progress at reset release is
  // not mistaken for a fresh rising edge; the block waits for hsync to drop.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b0;
      line_active <= 1'b0;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_sel      <= 1'b0;
      overflow    <= 1'b0;
      short_line  <= 1'b0;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      if (start_ok) begin
        if (full[wr_sel]) overflow    <= 1'b1;
        else              line_active <= 1'b1;
      end
      if (capture) wr_x <= wr_x + 9'd1;
      if (hs_fall && line_active) begin
        line_active <= 1'b0;
        wr_x        <= '0;
        if (wr_x == X_FULL) begin
          wr_sel <= ~wr_sel;
          if (wr_y != Y_LAST) wr_y <= wr_y + 8'd1;
        end else begin
          short_line <= 1'b1;
        end
      end
      if (vs_fall) wr_y <= '0;
    end
  end

  // Full flags and row tags; a commit and a drain always target different
  // buffers, so both bit updates land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full       <= '0;
      row_tag[0] <= '0;
      row_tag[1] <= '0;
    end else begin
      if (commit) begin
        full[wr_sel]    <= 1'b1;
        row_tag[wr_sel] <= wr_y;
      end
      if (drain) full[rd_sel] <= 1'b0;
    end
  end

  // Line buffer RAM: capture writes and registered replay reads.
  // NOTE: RAM contents are deliberately left unreset; full flags gate every
  // read, so stale words are never presented.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_sel][wr_x] <= color;
    if (rd_en)   rd_data <= mem[rd_sel][rd_addr];
  end

  assign accept = (state == SEND) && beat.out_ready;

  // Replay FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Replay FSM next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (full[rd_sel]) state_next = FETCH;
      FETCH:   state_next = SEND;
      SEND:    if (accept && (rd_x == X_LAST)) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Replay FSM outputs: stream beat, RAM prefetch and buffer release.
  always_comb begin
    beat.out_valid = 1'b0;
    beat.out_data  = '0;
    beat.out_x     = '0;
    beat.out_y     = '0;
    beat.out_sof   = 1'b0;
    beat.out_eol   = 1'b0;
    rd_en          = 1'b0;
    rd_addr        = rd_x + 9'd1;
    drain          = 1'b0;
    unique case (state)
      FETCH: begin
        rd_en   = 1'b1;
        rd_addr = '0;
      end
      SEND: begin
        beat.out_valid = 1'b1;
        beat.out_data  = rd_data;
        beat.out_x     = rd_x;
        beat.out_y     = row_tag[rd_sel];
        beat.out_sof   = (rd_x == '0) && (row_tag[rd_sel] == '0);
        beat.out_eol   = (rd_x == X_LAST);
        // Prefetch the next column only when this beat is taken, so a stall
        // leaves rd_data untouched.
        rd_en          = accept && (rd_x != X_LAST);
      end
      DRAIN:   drain = 1'b1;
      default: ;
    endcase
  end

  // Replay column counter and read-buffer select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_x   <= '0;
      rd_sel <= 1'b0;
    end else begin
      if (state == FETCH)  rd_x <= '0;
      else if (accept)     rd_x <= (rd_x == X_LAST) ? 9'd0 : rd_x + 9'd1;
      if (drain)           rd_sel <= ~rd_sel;
    end
  end

endmodule
